// File: rtl/beam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beam_pkg : shared widths and channel helper for the 16-mic beamformer       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package beam_pkg;

    localparam int NUM_CH   = 16;
    localparam int DATA_W   = 19;
    localparam int CH_IDX_W = $clog2(NUM_CH);
    localparam int SUM_W    = DATA_W + CH_IDX_W;
    localparam int SQ_W     = 2 * DATA_W - 1;

    function automatic logic signed [DATA_W-1:0] get_ch(
        input logic [NUM_CH*DATA_W-1:0] bus,
        input int unsigned              idx
    );
        return bus[idx*DATA_W +: DATA_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/beam_energy_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beam_energy_acc : squares beam samples and integrates per-frame energy      |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module beam_energy_acc
    import beam_pkg::*;
#(
    parameter int ACC_W     = 48,
    parameter int FRAME_LEN = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sum_valid,
    input  logic signed [DATA_W-1:0] sum_out,
    input  logic                     frame_restart,
    output logic                     energy_valid,
    output logic [ACC_W-1:0]         energy,
    output logic                     energy_sat
);

    localparam int                CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [DATA_W-1:0] mag;
    logic [SQ_W-1:0]   sq_d, sq_q;
    logic              sq_vld_d, sq_vld_q;
    logic [ACC_W-1:0]  acc_d, acc_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              sat_d, sat_q;
    logic [ACC_W-1:0]  energy_d, energy_q;
    logic              energy_sat_d, energy_sat_q;
    logic              energy_valid_d, energy_valid_q;
    logic [ACC_W:0]    acc_sum;
    logic              acc_ovf;
    logic [ACC_W-1:0]  acc_next;

    // Squaring the magnitude keeps the product unsigned and SQ_W bits wide.
    always_comb begin
        mag      = sum_out[DATA_W-1] ? DATA_W'(-sum_out) : DATA_W'(sum_out);
        acc_sum  = {1'b0, acc_q} + (ACC_W+1)'(sq_q);
        acc_ovf  = acc_sum[ACC_W];
        acc_next = acc_ovf ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    end

    always_comb begin
        sq_d           = sq_q;
        sq_vld_d       = sum_valid;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        sat_d          = sat_q;
        energy_d       = energy_q;
        energy_sat_d   = energy_sat_q;
        energy_valid_d = 1'b0;
        if (sum_valid) begin
            sq_d = SQ_W'(mag) * SQ_W'(mag);
        end
        // Restart outranks any accumulate landing on the same edge, including the last one.
        if (frame_restart) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (sq_vld_q) begin
            if (cnt_q == CNT_LAST) begin
                energy_d       = acc_next;
                energy_sat_d   = sat_q | acc_ovf;
                energy_valid_d = 1'b1;
                acc_d          = '0;
                cnt_d          = '0;
                sat_d          = 1'b0;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                sat_d = sat_q | acc_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_q           <= '0;
            sq_vld_q       <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
            sat_q          <= 1'b0;
            energy_q       <= '0;
            energy_sat_q   <= 1'b0;
            energy_valid_q <= 1'b0;
        end else begin
            sq_q           <= sq_d;
            sq_vld_q       <= sq_vld_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            sat_q          <= sat_d;
            energy_q       <= energy_d;
            energy_sat_q   <= energy_sat_d;
            energy_valid_q <= energy_valid_d;
        end
    end

    assign energy_valid = energy_valid_q;
    assign energy       = energy_q;
    assign energy_sat   = energy_sat_q;

endmodule
`default_nettype wire

// File: rtl/beam_sum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beam_sum : delay-and-sum combiner with rounded mean and frame energy        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module beam_sum #(
    parameter int NUM_CH    = beam_pkg::NUM_CH,
    parameter int DATA_W    = beam_pkg::DATA_W,
    parameter int ACC_W     = 48,
    parameter int FRAME_LEN = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic [NUM_CH*DATA_W-1:0]             pcm_in,
    input  logic [NUM_CH-1:0]                    ch_enable,
    input  logic                                 frame_restart,
    output logic                                 sum_full_valid,
    output logic signed [DATA_W+$clog2(NUM_CH)-1:0] sum_full,
    output logic                                 sum_valid,
    output logic signed [DATA_W-1:0]             sum_out,
    output logic                                 energy_valid,
    output logic [ACC_W-1:0]                     energy,
    output logic                                 energy_sat
);

    localparam int LVLS  = $clog2(NUM_CH);
    localparam int SUM_W = DATA_W + LVLS;

    logic signed [DATA_W-1:0] masked [NUM_CH];
    logic [LVLS:1]            tree_vld_d, tree_vld_q;
    logic signed [DATA_W-1:0] sum_out_d, sum_out_q;
    logic                     sum_valid_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_mask
        assign masked[c] = ch_enable[c] ? pcm_in[c*DATA_W +: DATA_W] : '0;
    end

    // Level k holds NUM_CH>>k partial sums, each one bit wider than its inputs.
    for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
        localparam int W = DATA_W + k;
        localparam int N = NUM_CH >> k;

        logic signed [W-2:0] src    [2*N];
        logic signed [W-1:0] node_d [N];
        logic signed [W-1:0] node_q [N];
        logic                load;

        if (k == 1) begin : g_src_in
            for (genvar j = 0; j < 2*N; j++) begin : g_src
                assign src[j] = masked[j];
            end
            assign load = in_valid;
        end else begin : g_src_lvl
            for (genvar j = 0; j < 2*N; j++) begin : g_src
                assign src[j] = g_lvl[k-1].node_q[j];
            end
            assign load = tree_vld_q[k-1];
        end

        always_comb begin
            for (int j = 0; j < N; j++) begin
                node_d[j] = {src[2*j][W-2], src[2*j]} + {src[2*j+1][W-2], src[2*j+1]};
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j < N; j++) begin
                    node_q[j] <= '0;
                end
            end else if (load) begin
                for (int j = 0; j < N; j++) begin
                    node_q[j] <= node_d[j];
                end
            end
        end
    end

    // floor((x + NUM_CH/2) / NUM_CH) equals the upper bits plus the bit just below them.
    always_comb begin
        tree_vld_d = {tree_vld_q[LVLS-1:1], in_valid};
        sum_out_d  = sum_out_q;
        if (sum_full_valid) begin
            sum_out_d = sum_full[SUM_W-1:LVLS] + {{(DATA_W-1){1'b0}}, sum_full[LVLS-1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tree_vld_q  <= '0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            tree_vld_q  <= tree_vld_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_full_valid;
        end
    end

    assign sum_full_valid = tree_vld_q[LVLS];
    assign sum_full       = g_lvl[LVLS].node_q[0];
    assign sum_valid      = sum_valid_q;
    assign sum_out        = sum_out_q;

    beam_energy_acc #(
        .ACC_W     (ACC_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_energy (
        .clk           (clk),
        .rst           (rst),
        .sum_valid     (sum_valid_q),
        .sum_out       (sum_out_q),
        .frame_restart (frame_restart),
        .energy_valid  (energy_valid),
        .energy        (energy),
        .energy_sat    (energy_sat)
    );

endmodule
`default_nettype wire

// File: tb/tb_beam_sum.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_beam_sum : directed and random stimulus against a frame-level model      |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_beam_sum;

    localparam int     NCH  = 16;
    localparam int     DW   = 19;
    localparam int     SW   = 23;
    localparam int     AW   = 37;
    localparam int     FL   = 4;
    localparam int     MAXC = 2048;
    localparam longint EMAX = (64'sd1 <<< AW) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [NCH*DW-1:0]     pcm_in;
    logic [NCH-1:0]        ch_enable;
    logic                  frame_restart;
    logic                  sum_full_valid;
    logic signed [SW-1:0]  sum_full;
    logic                  sum_valid;
    logic signed [DW-1:0]  sum_out;
    logic                  energy_valid;
    logic [AW-1:0]         energy;
    logic                  energy_sat;

    beam_sum #(.NUM_CH(NCH), .DATA_W(DW), .ACC_W(AW), .FRAME_LEN(FL)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .pcm_in         (pcm_in),
        .ch_enable      (ch_enable),
        .frame_restart  (frame_restart),
        .sum_full_valid (sum_full_valid),
        .sum_full       (sum_full),
        .sum_valid      (sum_valid),
        .sum_out        (sum_out),
        .energy_valid   (energy_valid),
        .energy         (energy),
        .energy_sat     (energy_sat)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    bit     chk_en = 1'b0;

    // Expectations indexed by the cycle in which they must be visible.
    bit     exp_sfv [MAXC];
    longint exp_sf  [MAXC];
    bit     exp_sv  [MAXC];
    longint exp_so  [MAXC];
    bit     acc_v   [MAXC];
    longint acc_sq  [MAXC];
    bit     rs_at   [MAXC];
    bit     exp_ev  [MAXC];
    longint exp_en  [MAXC];
    bit     exp_es  [MAXC];

    longint e_cur     = 0;
    bit     sat_cur   = 1'b0;
    longint frame_sum = 0;
    int     frame_n   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [NCH*DW-1:0] fill(input int v);
        logic [NCH*DW-1:0] p;
        for (int i = 0; i < NCH; i++) p[i*DW +: DW] = DW'(v);
        return p;
    endfunction

    // One clock of stimulus; the expected beam sum is the plain sum of enabled channels.
    task automatic step(input bit v, input logic [NCH-1:0] en, input logic [NCH*DW-1:0] pcm, input bit rs);
        longint s;
        longint r;
        logic signed [DW-1:0] x;
        if (cyc > MAXC - 8) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 8);
            $fatal(1, "cycle budget exhausted");
        end
        in_valid      = v;
        ch_enable     = en;
        pcm_in        = pcm;
        frame_restart = rs;
        rs_at[cyc]    = rs;
        if (v) begin
            s = 0;
            for (int i = 0; i < NCH; i++) begin
                if (en[i]) begin
                    x = pcm[i*DW +: DW];
                    s += x;
                end
            end
            r = (s + NCH/2) >>> 4;
            exp_sfv[cyc+4] = 1'b1;  exp_sf[cyc+4] = s;
            exp_sv[cyc+5]  = 1'b1;  exp_so[cyc+5] = r;
            acc_v[cyc+6]   = 1'b1;  acc_sq[cyc+6] = r * r;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '1, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = cyc; i < MAXC; i++) begin
            exp_sfv[i] = 0; exp_sv[i] = 0; acc_v[i] = 0; rs_at[i] = 0; exp_ev[i] = 0;
        end
        frame_sum = 0;
        frame_n   = 0;
        e_cur     = 0;
        sat_cur   = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_ev[cyc]) begin
                e_cur   = exp_en[cyc];
                sat_cur = exp_es[cyc];
            end
            chk("sum_full_valid", sum_full_valid, exp_sfv[cyc]);
            if (exp_sfv[cyc]) chk("sum_full", sum_full, exp_sf[cyc]);
            chk("sum_valid", sum_valid, exp_sv[cyc]);
            if (exp_sv[cyc]) chk("sum_out", sum_out, exp_so[cyc]);
            chk("energy_valid", energy_valid, exp_ev[cyc]);
            chk("energy", energy, e_cur);
            chk("energy_sat", energy_sat, sat_cur);
            if (rs_at[cyc]) begin
                frame_sum = 0;
                frame_n   = 0;
            end else if (acc_v[cyc]) begin
                frame_sum += acc_sq[cyc];
                frame_n++;
                if (frame_n == FL) begin
                    exp_ev[cyc+1] = 1'b1;
                    exp_en[cyc+1] = (frame_sum > EMAX) ? EMAX : frame_sum;
                    exp_es[cyc+1] = (frame_sum > EMAX);
                    frame_sum = 0;
                    frame_n   = 0;
                end
            end
        end
    end

    initial begin
        logic [NCH*DW-1:0] p;
        rst = 1'b0; in_valid = 1'b0; pcm_in = '0; ch_enable = '1; frame_restart = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_sum_full", sum_full, 0);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_energy", energy, 0);
        chk("rst_energy_sat", energy_sat, 0);
        idle(2);
        rst = 1'b1;

        // Single pulse, all channels +1000.
        idle(10 - cyc);
        step(1'b1, '1, fill(1000), 1'b0);
        idle(8);
        chk("held_sum_full_1000", sum_full, 16000);
        chk("held_sum_out_1000", sum_out, 1000);

        // Rounding and extreme values.
        p = fill(262143);
        for (int i = 8; i < NCH; i++) p[i*DW +: DW] = DW'(-262144);
        step(1'b1, '1, p, 1'b0);
        step(1'b1, '1, fill(262143), 1'b0);
        step(1'b1, '1, fill(-262144), 1'b0);
        idle(8);
        chk("held_sum_full_min", sum_full, -4194304);
        chk("held_sum_out_min", sum_out, -262144);

        // Channel masking; the divisor stays at NUM_CH.
        p = fill(5000);
        p[DW-1:0] = DW'(24);
        step(1'b1, 16'h0001, p, 1'b0);
        step(1'b1, 16'h0000, p, 1'b0);
        idle(8);
        chk("held_sum_out_masked", sum_out, 0);

        // Frames of sum_out=3, back to back and then with 3-cycle gaps.
        step(1'b0, '1, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, '1, fill(3), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, '1, fill(3), 1'b0);
            idle(3);
        end
        idle(10);
        chk("frame_energy_36", energy, 36);
        chk("frame_sat_36", energy_sat, 0);

        // Saturating frame, then an all-zero frame.
        step(1'b0, '1, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, '1, fill(-262144), 1'b0);
        idle(10);
        chk("sat_energy", energy, EMAX);
        chk("sat_flag", energy_sat, 1);
        for (int i = 0; i < 4; i++) step(1'b1, '1, '0, 1'b0);
        idle(10);
        chk("zero_energy", energy, 0);
        chk("zero_sat", energy_sat, 0);

        // Restart on the last-sample accumulate suppresses the frame.
        for (int i = 0; i < 4; i++) step(1'b1, '1, fill(3), 1'b0);
        idle(5);
        step(1'b0, '1, '0, 1'b1);
        idle(10);
        chk("restart_last_held", energy, 0);

        // Mid-frame reset discards the partial frame.
        for (int i = 0; i < 2; i++) step(1'b1, '1, fill(3), 1'b0);
        idle(3);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, '1, fill(1000), 1'b0);
        idle(10);
        chk("post_reset_energy", energy, 64'sd4000000);

        // Random traffic with occasional restarts.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) p[i*DW +: DW] = DW'($urandom);
            step($urandom_range(0, 9) < 7, NCH'($urandom), p, $urandom_range(0, 49) == 0);
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
